i2s_audio_in: RTL and testbench



---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_sync_edge.sv | 34 +++
 rtl/i2s_audio_in.sv | 140 ++++++++++++++
 tb/tb_i2s_audio_in.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive path: synchronizer depth, FSM states
// and the bit counter sizing helper.
package i2s_pkg;

  localparam int sync_stages = 2;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    CAPTURE,
    SKIP
  } i2s_rx_state_t;

  // bit_cnt must be able to hold w_sample itself, not just w_sample-1
  function automatic int bit_cnt_width(input int w_sample);
    return $clog2(w_sample + 1);
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for a group of async pins; the edge_i pin also gets
// an extra flop and a rising-edge strobe aligned with the synchronized data.
module i2s_sync_edge
  import i2s_pkg::*;
#(
  parameter int stages = sync_stages,
  parameter int width  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             edge_i,
  input  logic [width-1:0] data_i,
  output logic [width-1:0] data_o,
  output logic             rise_o
);

  // bit 0 carries edge_i so that all pins see identical synchronizer delay
  logic [stages-1:0][width:0] sync_q;
  logic                       edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[stages-2:0], {data_i, edge_i}};
      edge_q <= sync_q[stages-1][0];
    end
  end

  assign data_o = sync_q[stages-1][width:1];
  assign rise_o = sync_q[stages-1][0] & ~edge_q;

endmodule

// File: rtl/i2s_audio_in.sv
// I2S receiver: oversamples bclk/lrclk/sdata in the clk domain, deserializes
// left and right words and presents them as one stereo sample with valid.
module i2s_audio_in
  import i2s_pkg::*;
#(
  parameter int clk_mhz  = 50,
  parameter int w_sample = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [w_sample-1:0] left,
  output logic [w_sample-1:0] right,
  output logic                valid
);

  localparam int                cnt_w    = bit_cnt_width(w_sample);
  localparam logic [cnt_w-1:0]  last_cnt = cnt_w'(w_sample - 1);

  if (clk_mhz < 4 || w_sample < 2) begin : g_param_check
    $error("i2s_audio_in: clk_mhz must be >= 4 and w_sample >= 2");
  end

  logic       rise;
  logic [1:0] pins_s;
  logic       lr_s;
  logic       sd_s;

  i2s_sync_edge #(
    .stages(sync_stages),
    .width (2)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .edge_i(bclk),
    .data_i({sdata, lrclk}),
    .data_o(pins_s),
    .rise_o(rise)
  );

  assign lr_s = pins_s[0];
  assign sd_s = pins_s[1];

  i2s_rx_state_t       state_q, state_d;
  logic [cnt_w-1:0]    bit_cnt_q, bit_cnt_d;
  logic                chan_q, chan_d;
  logic                lr_prev_q, lr_prev_d;
  logic                seen_q, seen_d;
  logic [w_sample-1:0] shreg_q, shreg_d;
  logic [w_sample-1:0] left_hold_q, left_hold_d;
  logic                left_ok_q, left_ok_d;
  logic [w_sample-1:0] left_q, left_d;
  logic [w_sample-1:0] right_q, right_d;
  logic                valid_q, valid_d;

  logic [w_sample-1:0] shift_val;
  logic                lr_chg;

  assign shift_val = {shreg_q[w_sample-2:0], sd_s};
  // seen_q keeps the reset value of the synchronizer from faking a transition
  assign lr_chg    = seen_q & (lr_s != lr_prev_q);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    chan_d      = chan_q;
    lr_prev_d   = lr_prev_q;
    seen_d      = seen_q;
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;

    if (rise) begin
      lr_prev_d = lr_s;
      seen_d    = 1'b1;
      if (lr_chg) begin
        // a left slot cut short breaks the pairing with the following right
        if (state_q == CAPTURE && !chan_q) begin
          left_ok_d = 1'b0;
        end
        state_d   = CAPTURE;
        bit_cnt_d = '0;
        chan_d    = lr_s;
      end else if (state_q == CAPTURE) begin
        shreg_d   = shift_val;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == last_cnt) begin
          state_d = SKIP;
          if (!chan_q) begin
            left_hold_d = shift_val;
            left_ok_d   = 1'b1;
          end else if (left_ok_q) begin
            left_d    = left_hold_q;
            right_d   = shift_val;
            valid_d   = 1'b1;
            left_ok_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_SYNC;
      bit_cnt_q   <= '0;
      chan_q      <= 1'b0;
      lr_prev_q   <= 1'b0;
      seen_q      <= 1'b0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      chan_q      <= chan_d;
      lr_prev_q   <= lr_prev_d;
      seen_q      <= seen_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
    end
  end

  assign left  = left_q;
  assign right = right_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_i2s_audio_in.sv
// Bench for i2s_audio_in: an I2S slot generator with a slot-level reference
// model feeding a scoreboard, and a monitor that checks every valid pulse.
module tb_i2s_audio_in;

  localparam int W    = 16;
  localparam int HALF = 8;
  localparam int SLOT = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         bclk = 1'b1;
  logic         lrclk = 1'b1;
  logic         sdata = 1'b0;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic         valid;

  always #5 clk = ~clk;

  i2s_audio_in #(
    .clk_mhz (50),
    .w_sample(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bclk (bclk),
    .lrclk(lrclk),
    .sdata(sdata),
    .left (left),
    .right(right),
    .valid(valid)
  );

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   valid_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t mon_e;

  // slot-level model state
  bit           prev_left_ok = 1'b0;
  logic [W-1:0] prev_left_val = '0;
  logic [W-1:0] model_left = '0;
  logic [W-1:0] model_right = '0;
  bit           framed_next = 1'b0;
  bit           last_bit = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("left", {16'h0, left}, {16'h0, mon_e.l});
        check("right", {16'h0, right}, {16'h0, mon_e.r});
        check("valid_latency", 32'(cyc >= mon_e.due + 2 && cyc <= mon_e.due + 4), 32'd1);
        $display("frame at cycle %0d: left=%h right=%h", cyc, left, right);
      end
    end
  end

  function automatic logic [31:0] pad(input logic [15:0] v);
    return {v, 16'($urandom)};
  endfunction

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (ncyc) begin
      @(negedge clk);
      check("reset_left", {16'h0, left}, 32'h0);
      check("reset_right", {16'h0, right}, 32'h0);
      check("reset_valid", {31'h0, valid}, 32'h0);
    end
    rst           = 1'b0;
    prev_left_ok  = 1'b0;
    model_left    = '0;
    model_right   = '0;
    framed_next   = 1'b0;
  endtask

  // One slot of nper bclk periods; sdata lags lrclk by one bit as in I2S.
  task automatic send_slot(input bit ch, input logic [31:0] word, input int nper,
                           input int rst_at = -1);
    bit framed = framed_next;
    bit broke  = 1'b0;
    bit complete;
    framed_next = 1'b1;
    for (int p = 0; p < nper; p++) begin
      bclk  = 1'b0;
      lrclk = ch;
      sdata = (p == 0) ? last_bit : word[31-(p-1)];
      if (p == rst_at) begin
        do_reset(3);
        broke       = 1'b1;
        framed_next = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      if (ch && p == W && framed && !broke && prev_left_ok) begin
        exp_q.push_back('{l: prev_left_val, r: word[31-:W], due: cyc});
        model_left  = prev_left_val;
        model_right = word[31-:W];
      end
      bclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    last_bit = word[31-(nper-1)];
    complete = framed && !broke && (nper >= W + 1);
    if (!ch) begin
      prev_left_ok = complete;
      if (complete) prev_left_val = word[31-:W];
    end else begin
      prev_left_ok = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] l32, input logic [31:0] r32);
    send_slot(1'b0, l32, SLOT);
    send_slot(1'b1, r32, SLOT);
  endtask

  initial begin
    int n0;
    int len_l;
    int len_r;
    @(negedge clk);
    do_reset(3);

    // basic frame after an idle partial right slot
    send_slot(1'b1, $urandom, 4);
    send_frame(pad(16'h8001), pad(16'h7FFE));

    // stream resumes mid right slot with no lrclk edge seen since reset
    do_reset(2);
    send_slot(1'b1, $urandom, 20);
    send_frame(pad(16'($urandom)), pad(16'($urandom)));

    // short right slot: no frame, outputs hold
    send_slot(1'b0, pad(16'h1234), SLOT);
    send_slot(1'b1, pad(16'hBEEF), 8);
    check("hold_left", {16'h0, left}, {16'h0, model_left});
    check("hold_right", {16'h0, right}, {16'h0, model_right});
    send_frame(pad(16'h0AAA), pad(16'h0555));

    // reset in the middle of a right word
    send_slot(1'b0, pad(16'h5A5A), SLOT);
    send_slot(1'b1, pad(16'hC3C3), SLOT, 10);
    send_frame(pad(16'hFFFF), pad(16'h0001));

    // back-to-back frames are exactly one frame apart
    n0 = valid_cyc.size();
    send_frame(pad(16'h0001), pad(16'h0100));
    send_frame(pad(16'h0002), pad(16'h0200));
    send_frame(pad(16'h0003), pad(16'h0300));
    check("b2b_count", 32'(valid_cyc.size() - n0), 32'd3);
    if (valid_cyc.size() >= n0 + 3) begin
      check("b2b_gap1", 32'(valid_cyc[n0+1] - valid_cyc[n0]), 32'd1024);
      check("b2b_gap2", 32'(valid_cyc[n0+2] - valid_cyc[n0+1]), 32'd1024);
    end

    // 24-bit words truncated to the top 16 bits
    send_frame({24'hABCDEF, 8'($urandom)}, {24'h123456, 8'($urandom)});

    // random frames with occasional short slots
    for (int f = 0; f < 8; f++) begin
      len_l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 16)) : SLOT;
      len_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 16)) : SLOT;
      send_slot(1'b0, $urandom, len_l);
      send_slot(1'b1, $urandom, len_r);
    end

    repeat (20) @(negedge clk);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
